// File: rtl/ama_riscv_hazard_ctrl.sv
// Hazard and forwarding controller for the ama-riscv pipeline.
// A shift-register scoreboard follows every in-flight register write through
// STAGES post-decode stages (index 0 = exe). Decode gets a per-operand forward
// select (0 = regfile, k = result of stage k-1). A load-use hazard stalls
// decode and injects a bubble. A saturating counter tallies hazard-stall cycles.
module ama_riscv_hazard_ctrl #(
    parameter int STAGES     = 2,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_rs1_used,
    input  logic             dec_rs2_used,
    input  logic [4:0]       dec_rd,
    input  logic             dec_rd_we,
    input  logic             dec_load,
    input  logic             flush,
    input  logic             hold,
    output logic             stall_dec,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    // Scoreboard: entry i describes the instruction currently in stage i.
    // Only the valid bits are control state; rd/load are payload and are
    // meaningful only while the matching valid bit is set.
    logic [STAGES-1:0] sb_vld;
    logic [4:0]        sb_rd [STAGES];
    logic [STAGES-1:0] sb_ld;

    logic haz_a;
    logic haz_b;
    logic accept;

    // Saturating increment: hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Youngest-match search per operand. Scanning from the oldest stage towards
    // stage 0 lets the youngest match overwrite older ones, so both the select
    // and the load-use flag come from the youngest producer only.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        haz_a     = 1'b0;
        haz_b     = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (dec_rs1_used && (dec_rs1 != 5'd0) && sb_vld[i] && (sb_rd[i] == dec_rs1)) begin
                fwd_a_sel = SEL_W'(i + 1);
                haz_a     = sb_ld[i] && (i < LOAD_STAGE);
            end
            if (dec_rs2_used && (dec_rs2 != 5'd0) && sb_vld[i] && (sb_rd[i] == dec_rs2)) begin
                fwd_b_sel = SEL_W'(i + 1);
                haz_b     = sb_ld[i] && (i < LOAD_STAGE);
            end
        end
    end

    // A redirect kills the decode instruction, so flush overrides any stall.
    assign stall_dec = dec_valid && (haz_a || haz_b) && !flush;

    // Only a live, non-stalled, non-flushed writer of a real register occupies
    // a scoreboard slot; everything else enters stage 0 as a bubble.
    assign accept = dec_valid && !stall_dec && !flush && dec_rd_we && (dec_rd != 5'd0);

    // Control state: valid bits advance and the stall counter counts unless frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_vld    <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                sb_vld[k] <= sb_vld[k-1];
            end
            sb_vld[0] <= accept;
            if (stall_dec) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // Payload: destination and load flag shift alongside the valid bits.
    always_ff @(posedge clk) begin
        if (!hold) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                sb_rd[k] <= sb_rd[k-1];
                sb_ld[k] <= sb_ld[k-1];
            end
            sb_rd[0] <= dec_rd;
            sb_ld[0] <= dec_load;
        end
    end

endmodule

// File: tb/tb_ama_riscv_hazard_ctrl.sv
// Bench for ama_riscv_hazard_ctrl: three configurations share one stimulus
// stream; each is compared every cycle against an in-flight instruction model.
module tb_ama_riscv_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic       dec_rs1_used = 1'b0, dec_rs2_used = 1'b0;
    logic       dec_rd_we = 1'b0, dec_load = 1'b0;
    logic       flush = 1'b0, hold = 1'b0;

    logic        a_stall, b_stall, c_stall;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic [2:0]  b_fwd_a, b_fwd_b;
    logic [1:0]  c_fwd_a, c_fwd_b;
    logic [31:0] a_cnt;
    logic [2:0]  b_cnt;
    logic [31:0] c_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ama_riscv_hazard_ctrl #(.STAGES(2), .LOAD_STAGE(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_load(dec_load),
        .flush(flush), .hold(hold), .stall_dec(a_stall),
        .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b), .stall_cnt(a_cnt)
    );

    ama_riscv_hazard_ctrl #(.STAGES(4), .LOAD_STAGE(3), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_load(dec_load),
        .flush(flush), .hold(hold), .stall_dec(b_stall),
        .fwd_a_sel(b_fwd_a), .fwd_b_sel(b_fwd_b), .stall_cnt(b_cnt)
    );

    ama_riscv_hazard_ctrl #(.STAGES(3), .LOAD_STAGE(0), .CNT_W(32)) dut_c (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_load(dec_load),
        .flush(flush), .hold(hold), .stall_dec(c_stall),
        .fwd_a_sel(c_fwd_a), .fwd_b_sel(c_fwd_b), .stall_cnt(c_cnt)
    );

    // Reference model: list of in-flight instructions per configuration,
    // position 0 = youngest (exe).
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       ld;
    } rec_t;

    localparam int     NST  [3] = '{2, 4, 3};
    localparam int     NLD  [3] = '{1, 3, 0};
    localparam longint MAXC [3] = '{64'hFFFF_FFFF, 64'd7, 64'hFFFF_FFFF};

    rec_t   mdl  [3][8];
    longint mcnt [3];
    int     e_sa [3];
    int     e_sb [3];
    bit     e_st [3];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int youngest(int c, logic [4:0] rs, logic used);
        if (!used || rs == 5'd0) return -1;
        for (int i = 0; i < NST[c]; i++)
            if (mdl[c][i].v && mdl[c][i].rd == rs) return i;
        return -1;
    endfunction

    function automatic void model_eval();
        for (int c = 0; c < 3; c++) begin
            int  ya, yb;
            bit  hz;
            ya = youngest(c, dec_rs1, dec_rs1_used);
            yb = youngest(c, dec_rs2, dec_rs2_used);
            e_sa[c] = (ya < 0) ? 0 : ya + 1;
            e_sb[c] = (yb < 0) ? 0 : yb + 1;
            hz = ((ya >= 0) && mdl[c][ya].ld && (ya < NLD[c])) ||
                 ((yb >= 0) && mdl[c][yb].ld && (yb < NLD[c]));
            e_st[c] = dec_valid && hz && !flush;
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 8; i++) mdl[c][i].v = 1'b0;
            mcnt[c] = 0;
        end
    endfunction

    function automatic void model_clock();
        if (rst) begin
            model_reset();
            return;
        end
        if (hold) return;
        for (int c = 0; c < 3; c++) begin
            for (int i = NST[c] - 1; i > 0; i--) mdl[c][i] = mdl[c][i-1];
            mdl[c][0].v  = dec_valid && !e_st[c] && !flush && dec_rd_we && (dec_rd != 5'd0);
            mdl[c][0].rd = dec_rd;
            mdl[c][0].ld = dec_load;
            if (e_st[c] && mcnt[c] < MAXC[c]) mcnt[c]++;
        end
    endfunction

    // One clock: compare all outputs on the falling edge, then advance the model.
    task automatic step();
        @(negedge clk);
        model_eval();
        chk("a_stall", a_stall, e_st[0]);
        chk("a_fwd_a", a_fwd_a, e_sa[0]);
        chk("a_fwd_b", a_fwd_b, e_sb[0]);
        chk("a_cnt",   a_cnt,   mcnt[0]);
        chk("b_stall", b_stall, e_st[1]);
        chk("b_fwd_a", b_fwd_a, e_sa[1]);
        chk("b_fwd_b", b_fwd_b, e_sb[1]);
        chk("b_cnt",   b_cnt,   mcnt[1]);
        chk("c_stall", c_stall, e_st[2]);
        chk("c_fwd_a", c_fwd_a, e_sa[2]);
        chk("c_fwd_b", c_fwd_b, e_sb[2]);
        chk("c_cnt",   c_cnt,   mcnt[2]);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic ins(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
        dec_valid    = 1'b1;
        dec_rd       = rd;
        dec_rd_we    = we;
        dec_load     = ld;
        dec_rs1      = rs1;
        dec_rs1_used = u1;
        dec_rs2      = rs2;
        dec_rs2_used = u2;
    endtask

    task automatic idle();
        ins(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        dec_valid = 1'b0;
    endtask

    initial begin
        longint cstart;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        idle();
        #1;
        chk("rst_stall", a_stall, 0);
        chk("rst_fwd_a", a_fwd_a, 0);
        chk("rst_fwd_b", a_fwd_b, 0);
        chk("rst_cnt", a_cnt, 0);
        step();

        // add x5 ; add rs1=x5 ; add rs1=x5
        ins(5, 1, 0, 0, 0, 0, 0); step();
        ins(9, 1, 0, 5, 1, 0, 0); #1;
        chk("tp_fwd_exe", a_fwd_a, 1); chk("tp_fwd_exe_stall", a_stall, 0); step();
        ins(10, 1, 0, 5, 1, 0, 0); #1;
        chk("tp_fwd_mem", a_fwd_a, 2); step();

        // lw x6 ; add rs2=x6
        ins(6, 1, 1, 0, 0, 0, 0); step();
        ins(11, 1, 0, 0, 0, 6, 1); #1;
        chk("tp_lu_stall", a_stall, 1); step();
        #1;
        chk("tp_lu_release", a_stall, 0);
        chk("tp_lu_fwd", a_fwd_b, 2);
        chk("tp_lu_cnt", a_cnt, 1); step();

        // x0 and unused operand
        ins(0, 1, 0, 0, 0, 0, 0); step();
        ins(12, 1, 0, 0, 1, 0, 1); #1;
        chk("tp_x0", a_fwd_a, 0); step();
        ins(3, 1, 0, 0, 0, 0, 0); step();
        ins(13, 1, 0, 3, 0, 0, 0); #1;
        chk("tp_unused", a_fwd_a, 0); step();

        // youngest producer wins
        ins(7, 1, 0, 0, 0, 0, 0); step();
        ins(7, 1, 0, 0, 0, 0, 0); step();
        ins(14, 1, 0, 7, 1, 0, 0); #1;
        chk("tp_young", a_fwd_a, 1); step();
        ins(7, 1, 1, 0, 0, 0, 0); step();
        ins(7, 1, 0, 0, 0, 0, 0); step();
        ins(15, 1, 0, 7, 1, 0, 0); #1;
        chk("tp_shadow_stall", a_stall, 0); chk("tp_shadow_fwd", a_fwd_a, 1); step();

        // load-use under hold
        ins(6, 1, 1, 0, 0, 0, 0); step();
        cstart = mcnt[0];
        ins(16, 1, 0, 0, 0, 6, 1);
        hold = 1'b1;
        repeat (3) begin
            #1;
            chk("tp_hold_stall", a_stall, 1);
            step();
            chk("tp_hold_cnt", a_cnt, cstart);
        end
        hold = 1'b0; #1;
        chk("tp_hold_rel_stall", a_stall, 1); step();
        chk("tp_hold_rel_cnt", a_cnt, cstart + 1);
        chk("tp_hold_rel_fwd", a_fwd_b, 2); step();

        // flush during hazard
        ins(6, 1, 1, 0, 0, 0, 0); step();
        ins(17, 1, 0, 0, 0, 6, 1); flush = 1'b1; #1;
        chk("tp_flush_stall", a_stall, 0); step();
        flush = 1'b0; #1;
        chk("tp_flush_bubble_stall", a_stall, 0);
        chk("tp_flush_bubble_fwd", a_fwd_b, 2); step();

        // reset mid-stream
        ins(5, 1, 0, 0, 0, 0, 0); step();
        ins(18, 1, 0, 5, 1, 0, 0); rst = 1'b1; step();
        rst = 1'b0; #1;
        chk("tp_rst_fwd", a_fwd_a, 0);
        chk("tp_rst_cnt_a", a_cnt, 0);
        chk("tp_rst_cnt_b", b_cnt, 0); step();

        // deep pipeline: STAGES=4, LOAD_STAGE=3
        idle(); repeat (5) step();
        ins(6, 1, 1, 0, 0, 0, 0); step();
        ins(19, 1, 0, 0, 0, 6, 1);
        repeat (3) begin
            #1;
            chk("tp4_stall", b_stall, 1);
            chk("tp_ld0_stall", c_stall, 0);
            step();
        end
        #1;
        chk("tp4_release", b_stall, 0);
        chk("tp4_fwd", b_fwd_b, 4); step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(99) == 0);
            hold         = ($urandom_range(6) == 0);
            flush        = ($urandom_range(9) == 0);
            dec_valid    = ($urandom_range(4) != 0);
            dec_rd       = 5'($urandom_range(7));
            dec_rs1      = 5'($urandom_range(7));
            dec_rs2      = 5'($urandom_range(7));
            dec_rs1_used = 1'($urandom_range(1));
            dec_rs2_used = 1'($urandom_range(1));
            dec_rd_we    = ($urandom_range(3) != 0);
            dec_load     = ($urandom_range(2) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
